// File: rtl/async_event_sync.sv
// Multi-channel async input synchroniser with glitch filter, edge-qualified event pulses and
// sticky pending/overrun flags. Define ASYNC_EVT_CNT_EN to add saturating per-channel counters.
module async_event_sync #(
    parameter int unsigned CH          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       async_in,
    input  logic [2*CH-1:0]     edge_mode,
    input  logic [CH-1:0]       ack,
`ifdef ASYNC_EVT_CNT_EN
    input  logic [CH-1:0]       cnt_clr,
    output logic [CH*CNT_W-1:0] evt_cnt,
`endif
    output logic [CH-1:0]       level_out,
    output logic [CH-1:0]       pulse_out,
    output logic [CH-1:0]       pending,
    output logic [CH-1:0]       overrun
);

    localparam int unsigned    FcW    = $clog2(FILTER_LEN + 1);
    localparam logic [FcW-1:0] FcLast = FcW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q [CH];
    logic [CH-1:0]          sync_s;
    logic [FcW-1:0]         fc_q [CH];
    logic [FcW-1:0]         fc_d [CH];
    logic [CH-1:0]          level_q, level_d;
    logic [CH-1:0]          pulse_q;
    logic [CH-1:0]          pend_q, pend_d;
    logic [CH-1:0]          ovr_q, ovr_d;
    logic [CH-1:0]          evt;

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            sync_s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    always_comb begin
        level_d = level_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        evt     = '0;
        for (int i = 0; i < CH; i++) begin
            fc_d[i] = '0;
            // Any sample matching the current level restarts the acceptance count.
            if (sync_s[i] != level_q[i]) begin
                if (fc_q[i] == FcLast) begin
                    level_d[i] = ~level_q[i];
                    evt[i]     = level_q[i] ? edge_mode[2*i+1] : edge_mode[2*i];
                end else begin
                    fc_d[i] = fc_q[i] + 1'b1;
                end
            end
            if (ack[i]) begin
                pend_d[i] = evt[i];
                ovr_d[i]  = 1'b0;
            end else if (evt[i]) begin
                pend_d[i] = 1'b1;
                ovr_d[i]  = ovr_q[i] | pend_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                sync_q[i] <= '0;
                fc_q[i]   <= '0;
            end
            level_q <= '0;
            pulse_q <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], async_in[i]};
                fc_q[i]   <= fc_d[i];
            end
            level_q <= level_d;
            pulse_q <= evt;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    assign level_out = level_q;
    assign pulse_out = pulse_q;
    assign pending   = pend_q;
    assign overrun   = ovr_q;

`ifdef ASYNC_EVT_CNT_EN
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] cnt_q [CH];
    logic [CNT_W-1:0] cnt_d [CH];

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            cnt_d[i] = cnt_q[i];
            // A clear that coincides with an event keeps that event.
            if (cnt_clr[i]) begin
                cnt_d[i] = evt[i] ? CNT_W'(1) : '0;
            end else if (evt[i] && (cnt_q[i] != CntMax)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            evt_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W != 0);
`endif

endmodule

// File: tb/tb_async_event_sync.sv
// Randomised self-checking bench for async_event_sync against a cycle-level behavioural model.
module tb_async_event_sync;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int FL = 3;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     async_in;
    logic [2*CH-1:0]   edge_mode;
    logic [CH-1:0]     ack;
    logic [CH-1:0]     level_out, pulse_out, pending, overrun;
`ifdef ASYNC_EVT_CNT_EN
    logic [CH-1:0]     cnt_clr;
    logic [CH*CW-1:0]  evt_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    async_event_sync #(
        .CH          (CH),
        .SYNC_STAGES (SS),
        .FILTER_LEN  (FL),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .async_in  (async_in),
        .edge_mode (edge_mode),
        .ack       (ack),
`ifdef ASYNC_EVT_CNT_EN
        .cnt_clr   (cnt_clr),
        .evt_cnt   (evt_cnt),
`endif
        .level_out (level_out),
        .pulse_out (pulse_out),
        .pending   (pending),
        .overrun   (overrun)
    );

    // Reference model: history of sampled inputs, run length of disagreeing samples per channel.
    logic [CH-1:0]    m_level, m_pulse, m_pend, m_ovr, m_s;
    logic             m_e;
    int               m_run [CH];
    int               m_cnt [CH];
    logic [CH*CW-1:0] m_cnt_vec;
    logic [CH-1:0]    hist [$];

    always @(posedge clk) begin
        if (rst) begin
            m_level = '0; m_pulse = '0; m_pend = '0; m_ovr = '0; m_cnt_vec = '0;
            hist.delete();
            for (int i = 0; i < CH; i++) begin
                m_run[i] = 0;
                m_cnt[i] = 0;
            end
        end else begin
            m_s = (hist.size() >= SS) ? hist[hist.size()-SS] : '0;
            for (int i = 0; i < CH; i++) begin
                m_e = 1'b0;
                if (m_s[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == FL) begin
                        m_level[i] = ~m_level[i];
                        m_run[i]   = 0;
                        m_e        = m_level[i] ? edge_mode[2*i] : edge_mode[2*i+1];
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_pulse[i] = m_e;
                if (ack[i]) begin
                    m_ovr[i]  = 1'b0;
                    m_pend[i] = m_e;
                end else if (m_e) begin
                    if (m_pend[i]) m_ovr[i] = 1'b1;
                    m_pend[i] = 1'b1;
                end
`ifdef ASYNC_EVT_CNT_EN
                if (cnt_clr[i]) m_cnt[i] = m_e ? 1 : 0;
                else if (m_e && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
`endif
                m_cnt_vec[CW*i +: CW] = CW'(m_cnt[i]);
            end
            hist.push_back(async_in);
            if (hist.size() > SS) void'(hist.pop_front());
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        async_in = CH'($urandom);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({level_out, pulse_out, pending, overrun} !== '0) begin
                fails++;
                $display("FAIL reset_hold got=%h want=0", {level_out, pulse_out, pending, overrun});
            end
            async_in = CH'($urandom);
        end
        async_in = '0;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if ({level_out, pulse_out, pending, overrun} !== {m_level, m_pulse, m_pend, m_ovr}) begin
                fails++;
                $display("FAIL reset_release got=%h want=%h",
                         {level_out, pulse_out, pending, overrun}, {m_level, m_pulse, m_pend, m_ovr});
            end
        end
    endtask

    task automatic test_rise_ack();
        logic [2:0] exp3;
        edge_mode = 8'h01;
        async_in[0] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if ({level_out, pulse_out, pending, overrun} !== {m_level, m_pulse, m_pend, m_ovr}) begin
                fails++;
                $display("FAIL rise_model c=%0d got=%h want=%h", c,
                         {level_out, pulse_out, pending, overrun}, {m_level, m_pulse, m_pend, m_ovr});
            end
            exp3 = {1'(c >= 5), 1'(c == 5), 1'(c >= 5)};
            checks++;
            if ({level_out[0], pulse_out[0], pending[0]} !== exp3) begin
                fails++;
                $display("FAIL rise_latency c=%0d got=%b want=%b", c,
                         {level_out[0], pulse_out[0], pending[0]}, exp3);
            end
        end
        ack[0] = 1'b1;
        @(negedge clk);
        ack[0] = 1'b0;
        checks++;
        if ({pending[0], overrun[0]} !== 2'b00) begin
            fails++;
            $display("FAIL rise_ack got=%b want=00", {pending[0], overrun[0]});
        end
    endtask

    task automatic test_glitch();
        int glen, alen, np;
        edge_mode = 8'h05;
        glen = $urandom_range(1, FL - 1);
        async_in[1] = 1'b1;
        repeat (glen) @(negedge clk);
        async_in[1] = 1'b0;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if ({level_out[1], pulse_out[1], pending[1]} !== 3'b000) begin
                fails++;
                $display("FAIL glitch_reject len=%0d got=%b want=000", glen,
                         {level_out[1], pulse_out[1], pending[1]});
            end
        end
        alen = $urandom_range(FL, FL + 4);
        np = 0;
        async_in[1] = 1'b1;
        for (int c = 0; c < alen + 12; c++) begin
            if (c == alen) async_in[1] = 1'b0;
            @(negedge clk);
            if (pulse_out[1]) np++;
            checks++;
            if ({level_out, pulse_out, pending, overrun} !== {m_level, m_pulse, m_pend, m_ovr}) begin
                fails++;
                $display("FAIL glitch_model got=%h want=%h",
                         {level_out, pulse_out, pending, overrun}, {m_level, m_pulse, m_pend, m_ovr});
            end
        end
        checks++;
        if (np != 1 || pending[1] !== 1'b1) begin
            fails++;
            $display("FAIL glitch_accept pulses=%0d pend=%b want 1,1", np, pending[1]);
        end
        ack[1] = 1'b1;
        @(negedge clk);
        ack[1] = 1'b0;
    endtask

    task automatic test_toggle_overrun();
        int np, half;
        edge_mode = 8'h35;
        np = 0;
        for (int t = 0; t < 2; t++) begin
            half = $urandom_range(8, 12);
            async_in[2] = ~async_in[2];
            repeat (half) begin
                @(negedge clk);
                if (pulse_out[2]) np++;
                checks++;
                if ({level_out, pulse_out, pending, overrun} !== {m_level, m_pulse, m_pend, m_ovr}) begin
                    fails++;
                    $display("FAIL square_model got=%h want=%h",
                             {level_out, pulse_out, pending, overrun}, {m_level, m_pulse, m_pend, m_ovr});
                end
            end
            checks++;
            if (np != t + 1 || pending[2] !== 1'b1 || overrun[2] !== 1'(t == 1)) begin
                fails++;
                $display("FAIL square_flags t=%0d pulses=%0d pend=%b ovr=%b want %0d,1,%0d",
                         t, np, pending[2], overrun[2], t + 1, t);
            end
        end
        ack[2] = 1'b1;
        @(negedge clk);
        ack[2] = 1'b0;
        checks++;
        if ({pending[2], overrun[2]} !== 2'b00) begin
            fails++;
            $display("FAIL square_ack got=%b want=00", {pending[2], overrun[2]});
        end
        async_in[2] = ~async_in[2];
        repeat (4) @(negedge clk);
        ack[2] = 1'b1;
        @(negedge clk);
        ack[2] = 1'b0;
        checks++;
        if ({pulse_out[2], pending[2], overrun[2]} !== 3'b110) begin
            fails++;
            $display("FAIL ack_with_event got=%b want=110", {pulse_out[2], pending[2], overrun[2]});
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_all_channels();
        int nall, nother, bad;
        edge_mode = 8'h55;
        async_in = '1;
        repeat (8) @(negedge clk);
        ack = '1;
        @(negedge clk);
        ack = '0;
        edge_mode = 8'hAA;
        async_in = '0;
        nall = 0; nother = 0;
        repeat (10) begin
            @(negedge clk);
            if (pulse_out === 4'hF) nall++;
            else if (pulse_out !== 4'h0) nother++;
            checks++;
            if ({level_out, pulse_out, pending, overrun} !== {m_level, m_pulse, m_pend, m_ovr}) begin
                fails++;
                $display("FAIL allfall_model got=%h want=%h",
                         {level_out, pulse_out, pending, overrun}, {m_level, m_pulse, m_pend, m_ovr});
            end
        end
        checks++;
        if (nall != 1 || nother != 0) begin
            fails++;
            $display("FAIL allfall_pulses all=%0d other=%0d want 1,0", nall, nother);
        end
        ack = '1;
        @(negedge clk);
        ack = '0;
        edge_mode = 8'h00;
        async_in = '1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (pulse_out !== 4'h0 || pending !== 4'h0) bad++;
        end
        checks++;
        if (bad != 0 || level_out !== 4'hF) begin
            fails++;
            $display("FAIL mode_off bad=%0d level=%h want 0,f", bad, level_out);
        end
    endtask

    task automatic test_mid_filter_reset();
        async_in = '0;
        repeat (8) @(negedge clk);
        edge_mode = 8'h01;
        async_in[0] = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if ({level_out[0], pending[0]} !== 2'b11) begin
            fails++;
            $display("FAIL midrst_setup got=%b want=11", {level_out[0], pending[0]});
        end
        async_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({level_out, pulse_out, pending, overrun} !== '0) begin
                fails++;
                $display("FAIL midrst_clear got=%h want=0", {level_out, pulse_out, pending, overrun});
            end
        end
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            checks++;
            if ({level_out, pulse_out, pending} !== '0) begin
                fails++;
                $display("FAIL midrst_quiet got=%h want=0", {level_out, pulse_out, pending});
            end
        end
    endtask

`ifdef ASYNC_EVT_CNT_EN
    task automatic test_counter();
        cnt_clr = '1;
        @(negedge clk);
        cnt_clr = '0;
        checks++;
        if (evt_cnt !== '0) begin
            fails++;
            $display("FAIL cnt_clear got=%h want=0", evt_cnt);
        end
        edge_mode = 8'hC0;
        repeat (5) begin
            async_in[3] = ~async_in[3];
            repeat (8) begin
                @(negedge clk);
                checks++;
                if (evt_cnt !== m_cnt_vec) begin
                    fails++;
                    $display("FAIL cnt_model got=%h want=%h", evt_cnt, m_cnt_vec);
                end
            end
        end
        checks++;
        if (evt_cnt[7:6] !== 2'd3) begin
            fails++;
            $display("FAIL cnt_saturate got=%0d want=3", evt_cnt[7:6]);
        end
        async_in[3] = ~async_in[3];
        repeat (4) @(negedge clk);
        cnt_clr[3] = 1'b1;
        @(negedge clk);
        cnt_clr[3] = 1'b0;
        checks++;
        if ({pulse_out[3], evt_cnt[7:6]} !== 3'b101) begin
            fails++;
            $display("FAIL cnt_clr_with_event got=%b want=101", {pulse_out[3], evt_cnt[7:6]});
        end
        repeat (6) @(negedge clk);
    endtask
`endif

    task automatic test_random();
        repeat (600) begin
            @(negedge clk);
            checks++;
            if ({level_out, pulse_out, pending, overrun} !== {m_level, m_pulse, m_pend, m_ovr}) begin
                fails++;
                $display("FAIL random_model t=%0t got=%h want=%h", $time,
                         {level_out, pulse_out, pending, overrun}, {m_level, m_pulse, m_pend, m_ovr});
            end
`ifdef ASYNC_EVT_CNT_EN
            checks++;
            if (evt_cnt !== m_cnt_vec) begin
                fails++;
                $display("FAIL random_cnt t=%0t got=%h want=%h", $time, evt_cnt, m_cnt_vec);
            end
            for (int i = 0; i < CH; i++) cnt_clr[i] = ($urandom_range(0, 15) == 0);
`endif
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 4) == 0) async_in[i] = ~async_in[i];
                ack[i] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 19) == 0) edge_mode = (2*CH)'($urandom);
            rst = ($urandom_range(0, 149) == 0);
        end
        rst = 1'b0;
        ack = '0;
    endtask

    initial begin
        rst = 1'b1;
        async_in = '0;
        ack = '0;
        edge_mode = '0;
`ifdef ASYNC_EVT_CNT_EN
        cnt_clr = '0;
`endif
        test_reset();
        test_rise_ack();
        test_glitch();
        test_toggle_overrun();
        test_all_channels();
        test_mid_filter_reset();
`ifdef ASYNC_EVT_CNT_EN
        test_counter();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/async_event_sync.md
Name: async_event_sync

Overview:
- Multi-channel successor to the single-pulse domain-crossing block.
- Brings CH asynchronous inputs (echo/trigger lines, foreign-domain flags) into the clk domain through a SYNC_STAGES flop chain per channel.
- Each channel then passes a consecutive-sample glitch filter and a per-channel selectable edge detector.
- Produces one-cycle event pulses plus sticky pending/overrun flags with an ack handshake for the consuming FSM.

Parameters:
CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILTER_LEN, 3, consecutive cycles a synchronised level must differ from level_out before acceptance (>=1; 1 = no filtering)
CNT_W, 8, event counter width (used only with ASYNC_EVT_CNT_EN)

Ports:
clk  in  1  sole clock
rst  in  1  reset; synchronous, active-high
async_in  in  CH  asynchronous inputs; bit i = channel i
edge_mode  in  2*CH  per channel [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
ack  in  CH  clears pending[i]/overrun[i]
level_out  out  CH  filtered synchronised level
pulse_out  out  CH  one-cycle qualified-edge pulse
pending  out  CH  sticky: event occurred, not yet acked
overrun  out  CH  sticky: event occurred while pending already set and not acked

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge) clears all sync flops, filter counters, level_out, pulse_out, pending, overrun (and evt_cnt) to 0. rst dominates every other input.
- Sync chain: async_in[i] -> stage1 -> ... -> stageN each clk. s[i] = last stage. No logic between stages.
- Filter, per channel: counter fc, width clog2(FILTER_LEN+1).
  - If s == level_out: fc <= 0.
  - Else if fc == FILTER_LEN-1: level_out toggles, fc <= 0.
  - Else: fc <= fc+1.
  - A glitch shorter than FILTER_LEN cycles at s never reaches level_out. Any return to the old level restarts the count.
- Latency: a clean step on async_in sampled at edge k gives level_out changing at edge k+SYNC_STAGES+FILTER_LEN-1. With defaults, level_out changes 4 edges after first sampling. pulse_out asserts on the same edge.
- Edge qualification: rise = level_out 0->1, fall = 1->0.
  - pulse_out[i] is registered. It is 1 for exactly the one cycle in which level_out shows its new value, if edge_mode[i] selects that direction. Otherwise it is 0.
  - edge_mode is sampled combinationally at the toggle edge. Changing it mid-operation affects only subsequent toggles. Mode 00 still updates level_out.
- Pending/overrun, per channel, evaluated each edge with p = qualifying event this edge:
  - ack=1, p=0: pending<=0, overrun<=0.
  - ack=1, p=1: pending<=1, overrun<=0 (the new event is not lost).
  - ack=0, p=1: if pending=1 then overrun<=1; pending<=1.
  - ack=0, p=0: hold.
  - ack while pending=0 is harmless.
- Post-reset: if async_in is held high through reset, level_out rises after the normal latency and produces a rising event if enabled. Consumers mask with edge_mode=00 until settled.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- Max accepted toggle rate per channel: one per FILTER_LEN cycles.

Optional Feature:
- Macro: ASYNC_EVT_CNT_EN.
- Defined:
  - Adds input cnt_clr (CH) and output evt_cnt (CH*CNT_W, channel i at [CNT_W*i+CNT_W-1:CNT_W*i]).
  - Counter increments on each qualifying pulse and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 alone -> 0. cnt_clr together with a pulse -> 1.
  - Reset -> 0.
- Undefined: ports, counters and all associated logic are absent. Remaining behaviour is identical.

Test Plan:
- Defaults, edge_mode=01 on ch0, async_in[0] 0->1 and held -> level_out[0]=1 and pulse_out[0]=1 for one cycle, 4 edges after first sampled-high edge; pending[0]=1 until ack[0].
- ch1 glitch high for 2 cycles (FILTER_LEN=3) -> level_out[1], pulse_out[1], pending[1] stay 0; a 3-cycle high is accepted.
- ch2 edge_mode=11, square wave with 10-cycle half-period -> a pulse on every toggle. Second event without ack -> overrun[2]=1. ack[2] -> pending and overrun 0. ack coincident with an event -> pending stays 1, overrun 0.
- All 4 channels toggled on the same cycle with edge_mode=10 after a prior rise -> 4 fall pulses on the same cycle, no rise pulses; edge_mode=00 -> level_out tracks, no pulses or pending.
- rst asserted mid-filter (fc=1) and with pending=1 -> all outputs 0 next edge; no pulse emitted during or immediately after reset while the input is stable low.
- With ASYNC_EVT_CNT_EN, CNT_W=2: 5 qualifying events -> evt_cnt saturates at 3; cnt_clr coincident with an event -> 1.
